// File: rtl/tsn_gcl_scheduler.sv
// Gate control list scheduler for one TSN egress port.
// Plays a list of {gate vector, interval} entries from the oper bank while software
// fills the admin bank; the two banks are swapped only at a list-cycle boundary.
module tsn_gcl_scheduler #(
   parameter int unsigned       GCL_DEPTH     = 16,
   parameter int unsigned       IDX_W         = 4,
   parameter int unsigned       GATE_W        = 8,
   parameter int unsigned       INTV_W        = 20,
   parameter logic [GATE_W-1:0] DEFAULT_GATES = 8'hFF
) (
   input  logic              syc_clk_250m,
   input  logic              sys_reset,
   input  logic              init_finish,
   input  logic              cfg_enable,
   input  logic              cfg_wr_en,
   input  logic [IDX_W:0]    cfg_wr_addr,
   input  logic [GATE_W-1:0] cfg_wr_gate,
   input  logic [INTV_W-1:0] cfg_wr_intv,
   input  logic [IDX_W:0]    cfg_list_len,
   input  logic              cfg_commit,
   output logic [GATE_W-1:0] gate_state,
   output logic [IDX_W-1:0]  gate_idx,
   output logic              cycle_start,
   output logic              commit_ack,
   output logic              commit_pending,
   output logic              cfg_err,
   output logic              running
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   localparam int unsigned    MemDepth = 2 * GCL_DEPTH;
   localparam logic [IDX_W:0] DepthW   = GCL_DEPTH[IDX_W:0];

   // Both banks share one array; the bank select is the top address bit.
   logic [GATE_W-1:0] gate_mem [MemDepth];
   logic [INTV_W-1:0] intv_mem [MemDepth];

   logic [0:0]        state_q, state_d;
   logic [GATE_W-1:0] gate_state_q, gate_state_d;
   logic [IDX_W-1:0]  gate_idx_q, gate_idx_d;
   logic [INTV_W-1:0] cnt_q, cnt_d;
   logic              oper_sel_q, oper_sel_d;
   logic [IDX_W:0]    oper_len_q, oper_len_d;
   logic [IDX_W:0]    len_lat_q, len_lat_d;
   logic              pend_q, pend_d;
   logic              cycle_start_q, cycle_start_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              running_q, running_d;

   logic              wr_bad;
   logic              wr_ok;
   logic              commit_bad;
   logic              commit_ok;
   logic [IDX_W:0]    wr_ptr;
   logic              go;
   logic              at_last;
   logic              rd_bank;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W:0]    rd_ptr;
   logic [GATE_W-1:0] rd_gate;
   logic [INTV_W-1:0] rd_intv;
   logic [INTV_W-1:0] rd_cnt;

   assign wr_bad     = cfg_wr_en && (cfg_wr_addr >= DepthW);
   assign wr_ok      = sys_reset && cfg_wr_en && !wr_bad;
   assign commit_bad = cfg_commit && ((cfg_list_len == '0) || (cfg_list_len > DepthW));
   assign commit_ok  = cfg_commit && !commit_bad;
   // Writes always go to the admin bank, i.e. the one that a pending commit will swap in.
   assign wr_ptr     = {~oper_sel_q, cfg_wr_addr[IDX_W-1:0]};
   assign go         = cfg_enable && init_finish;
   assign at_last    = ({1'b0, gate_idx_q} == (oper_len_q - 1'b1));

   // Admin-bank write port; bank contents survive reset.
   always_ff @(posedge syc_clk_250m) begin
      if (wr_ok) begin
         gate_mem[wr_ptr] <= cfg_wr_gate;
         intv_mem[wr_ptr] <= cfg_wr_intv;
      end
   end

   // Select the entry loaded on the next edge: entry 0 on start or wrap, else the successor.
   // At a wrap with a commit pending the entry comes from the bank being swapped in.
   always_comb begin
      rd_idx  = ((state_q == StIdle) || at_last) ? '0 : gate_idx_q + 1'b1;
      rd_bank = ((state_q == StRun) && at_last && pend_q) ? ~oper_sel_q : oper_sel_q;
   end

   assign rd_ptr  = {rd_bank, rd_idx};
   assign rd_gate = gate_mem[rd_ptr];
   assign rd_intv = intv_mem[rd_ptr];
   // A zero interval still occupies one cycle.
   assign rd_cnt  = (rd_intv == '0) ? INTV_W'(1) : rd_intv;

   // Next-state logic for the IDLE/RUN sequencer, bank swap and commit bookkeeping.
   always_comb begin
      state_d       = state_q;
      gate_state_d  = gate_state_q;
      gate_idx_d    = gate_idx_q;
      cnt_d         = cnt_q;
      oper_sel_d    = oper_sel_q;
      oper_len_d    = oper_len_q;
      len_lat_d     = len_lat_q;
      pend_d        = pend_q;
      cycle_start_d = 1'b0;
      ack_d         = 1'b0;
      err_d         = wr_bad || commit_bad;
      running_d     = running_q;

      unique case (state_q)
         StIdle: begin
            gate_state_d = DEFAULT_GATES;
            gate_idx_d   = '0;
            running_d    = 1'b0;
            if (pend_q) begin
               // Swap first; entering RUN waits for the following cycle.
               oper_sel_d = ~oper_sel_q;
               oper_len_d = len_lat_q;
               pend_d     = 1'b0;
               ack_d      = 1'b1;
            end else if (go && (oper_len_q != '0)) begin
               state_d       = StRun;
               gate_idx_d    = rd_idx;
               gate_state_d  = rd_gate;
               cnt_d         = rd_cnt;
               cycle_start_d = 1'b1;
               running_d     = 1'b1;
            end
         end
         StRun: begin
            if (!go) begin
               // Abort to idle; a pending commit is kept and applied from IDLE.
               state_d      = StIdle;
               gate_state_d = DEFAULT_GATES;
               gate_idx_d   = '0;
               cnt_d        = '0;
               running_d    = 1'b0;
            end else if (cnt_q <= INTV_W'(1)) begin
               gate_idx_d   = rd_idx;
               gate_state_d = rd_gate;
               cnt_d        = rd_cnt;
               if (at_last) begin
                  cycle_start_d = 1'b1;
                  if (pend_q) begin
                     oper_sel_d = ~oper_sel_q;
                     oper_len_d = len_lat_q;
                     pend_d     = 1'b0;
                     ack_d      = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A new valid commit re-arms the swap and overwrites any latched length.
      if (commit_ok) begin
         pend_d    = 1'b1;
         len_lat_d = cfg_list_len;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge syc_clk_250m) begin
      if (!sys_reset) begin
         state_q       <= StIdle;
         gate_state_q  <= DEFAULT_GATES;
         gate_idx_q    <= '0;
         cnt_q         <= '0;
         oper_sel_q    <= 1'b0;
         oper_len_q    <= '0;
         len_lat_q     <= '0;
         pend_q        <= 1'b0;
         cycle_start_q <= 1'b0;
         ack_q         <= 1'b0;
         err_q         <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         gate_state_q  <= gate_state_d;
         gate_idx_q    <= gate_idx_d;
         cnt_q         <= cnt_d;
         oper_sel_q    <= oper_sel_d;
         oper_len_q    <= oper_len_d;
         len_lat_q     <= len_lat_d;
         pend_q        <= pend_d;
         cycle_start_q <= cycle_start_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         running_q     <= running_d;
      end
   end

   assign gate_state     = gate_state_q;
   assign gate_idx       = gate_idx_q;
   assign cycle_start    = cycle_start_q;
   assign commit_ack     = ack_q;
   assign commit_pending = pend_q;
   assign cfg_err        = err_q;
   assign running        = running_q;

endmodule

// File: tb/tb_tsn_gcl_scheduler.sv
// Bench for tsn_gcl_scheduler: a reference model predicts all outputs each cycle from the
// list timing (elapsed time within a list cycle), a monitor compares on the falling edge.
module tb_tsn_gcl_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init = 1'b0;
   logic        en = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [7:0]  wr_gate = '0;
   logic [19:0] wr_intv = '0;
   logic [4:0]  list_len = '0;
   logic        commit = 1'b0;
   logic [7:0]  gate_state;
   logic [3:0]  gate_idx;
   logic        cycle_start, commit_ack, commit_pending, cfg_err, running;

   tsn_gcl_scheduler dut (
      .syc_clk_250m  (clk),
      .sys_reset     (rst_n),
      .init_finish   (init),
      .cfg_enable    (en),
      .cfg_wr_en     (wr_en),
      .cfg_wr_addr   (wr_addr),
      .cfg_wr_gate   (wr_gate),
      .cfg_wr_intv   (wr_intv),
      .cfg_list_len  (list_len),
      .cfg_commit    (commit),
      .gate_state    (gate_state),
      .gate_idx      (gate_idx),
      .cycle_start   (cycle_start),
      .commit_ack    (commit_ack),
      .commit_pending(commit_pending),
      .cfg_err       (cfg_err),
      .running       (running)
   );

   always #2 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] m_gate [2][16];
   int         m_intv [2][16];
   int         m_sel = 0, m_len = 0, m_lat = 0, m_t = 0;
   bit         m_run = 0, m_pend = 0;

   typedef logic [16:0] exp_t;
   exp_t exp_q[$];

   function automatic int eff(int b, int i);
      return (m_intv[b][i] == 0) ? 1 : m_intv[b][i];
   endfunction

   function automatic int cyc_len();
      int s = 0;
      for (int i = 0; i < m_len; i++) s += eff(m_sel, i);
      return s;
   endfunction

   function automatic int entry_at(int t);
      int acc = 0;
      for (int i = 0; i < m_len; i++) begin
         acc += eff(m_sel, i);
         if (t < acc) return i;
      end
      return 0;
   endfunction

   // Model: evaluates the inputs present at each rising edge and predicts the outputs after it.
   always @(posedge clk) begin : model
      bit  err, cs, ack, cbad;
      int  wb, ix;
      logic [7:0] g;
      if (!rst_n) begin
         m_run = 0; m_pend = 0; m_len = 0; m_sel = 0; m_t = 0;
         exp_q.push_back({8'hFF, 4'd0, 5'b00000});
      end else begin
         wb   = 1 - m_sel;
         cbad = (list_len == 0) || (list_len > 16);
         err  = (wr_en && wr_addr >= 16) || (commit && cbad);
         cs   = 0;
         ack  = 0;
         if (!m_run) begin
            if (m_pend) begin
               m_sel = 1 - m_sel; m_len = m_lat; m_pend = 0; ack = 1;
            end else if (en && init && m_len != 0) begin
               m_run = 1; m_t = 0; cs = 1;
            end
         end else if (!(en && init)) begin
            m_run = 0;
         end else begin
            m_t++;
            if (m_t >= cyc_len()) begin
               m_t = 0; cs = 1;
               if (m_pend) begin
                  m_sel = 1 - m_sel; m_len = m_lat; m_pend = 0; ack = 1;
               end
            end
         end
         ix = m_run ? entry_at(m_t) : 0;
         g  = m_run ? m_gate[m_sel][ix] : 8'hFF;
         if (commit && !cbad) begin
            m_pend = 1; m_lat = int'(list_len);
         end
         exp_q.push_back({g, 4'(ix), cs, ack, m_pend, err, m_run});
         if (wr_en && wr_addr < 16) begin
            m_gate[wb][wr_addr] = wr_gate;
            m_intv[wb][wr_addr] = int'(wr_intv);
         end
      end
   end

   // Monitor: compare the DUT outputs against the oldest prediction.
   always @(negedge clk) begin : monitor
      exp_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {gate_state, gate_idx, cycle_start, commit_ack, commit_pending, cfg_err, running};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got gate=%h idx=%0d cs=%b ack=%b pend=%b err=%b run=%b required gate=%h idx=%0d cs=%b ack=%b pend=%b err=%b run=%b",
                     $time, a[16:9], a[8:5], a[4], a[3], a[2], a[1], a[0],
                     e[16:9], e[8:5], e[4], e[3], e[2], e[1], e[0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input int addr, input int gate, input int intv);
      wr_en = 1'b1; wr_addr = 5'(addr); wr_gate = 8'(gate); wr_intv = 20'(intv);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_commit(input int len);
      commit = 1'b1; list_len = 5'(len);
      tick();
      commit = 1'b0;
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      // Fill both banks so every entry is defined.
      for (int i = 0; i < 16; i++) wr(i, $urandom_range(0, 255), $urandom_range(0, 6));
      do_commit(16);
      idle(3);
      for (int i = 0; i < 16; i++) wr(i, $urandom_range(0, 255), $urandom_range(0, 6));
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;

      // Commit with init pending, then release init and run the 3-entry list.
      en = 1'b1;
      wr(0, 8'h01, 3); wr(1, 8'h02, 5); wr(2, 8'h80, 0);
      do_commit(3);
      idle(5);
      init = 1'b1;
      idle(30);

      // Swap lists at a cycle boundary, including a single-entry list.
      wr(0, 8'h11, 3); wr(1, 8'h22, 2);
      do_commit(2);
      idle(30);
      idle(2);
      wr(0, 8'hF0, 4);
      do_commit(1);
      idle(25);

      // Rejected commits and out-of-range write.
      do_commit(0);
      idle(2);
      do_commit(17);
      idle(2);
      wr(16, 8'hAA, 7);
      idle(10);

      // Disable mid-entry, then re-enable.
      idle(2);
      en = 1'b0;
      idle(3);
      en = 1'b1;
      idle(12);

      // Reset while running with a commit pending.
      wr(0, 8'h33, 2);
      do_commit(1);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(10);

      // Randomized traffic; writes are held off while a swap is pending.
      for (int c = 0; c < 3000; c++) begin
         rst_n  = ($urandom % 800) != 0;
         en     = ($urandom % 50) != 0;
         init   = ($urandom % 200) != 0;
         wr_en  = (($urandom % 10) < 3) && !m_pend;
         wr_addr = 5'($urandom_range(0, 16));
         wr_gate = 8'($urandom_range(0, 255));
         wr_intv = (($urandom % 50) == 0) ? 20'd30 : 20'($urandom_range(0, 6));
         commit   = ($urandom % 30) == 0;
         list_len = (($urandom % 20) == 0) ? 5'd17 : 5'($urandom_range(0, 6));
         tick();
      end
      wr_en = 1'b0;
      commit = 1'b0;
      rst_n = 1'b1;
      idle(3);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending predictions required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
